// File: rtl/instr_store.sv
// Multi-bank, run-time loadable instruction store.
// Fetches are registered with a one-cycle valid pulse, and any fetch at or past a bank's
// loaded length returns HALT_INST. A streaming loader fills one bank at a time and
// blocks fetches while it runs.
module instr_store #(
    parameter int unsigned    IW        = 20,
    parameter int unsigned    AW        = 9,
    parameter int unsigned    NBANK     = 4,
    parameter logic [IW-1:0]  HALT_INST = 20'b01110_00000_00000_00000
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    // fetch side
    input  logic [$clog2(NBANK)-1:0] i_bank_sel,
    input  logic [AW-1:0]            i_iptr,
    input  logic                     i_fetch_req,
    output logic                     o_fetch_ready,
    output logic [IW-1:0]            o_inst,
    output logic                     o_inst_valid,
    output logic                     o_inst_halt,
    // loader side
    input  logic                     i_load_start,
    input  logic [$clog2(NBANK)-1:0] i_load_bank,
    input  logic [IW-1:0]            i_load_data,
    input  logic                     i_load_valid,
    input  logic                     i_load_last,
    output logic                     o_load_ready,
    output logic                     o_load_busy,
    output logic                     o_load_err
);

    localparam int unsigned BW    = $clog2(NBANK);
    localparam int unsigned DEPTH = 1 << AW;

    typedef enum logic [0:0] {StIdle, StLoad} state_e;

    state_e             r_state;
    state_e             w_state_nxt;

    logic [IW-1:0]      r_mem [NBANK*DEPTH];
    logic [AW:0]        r_len [NBANK];
    logic [AW:0]        r_wcnt;
    logic [BW-1:0]      r_tbank;
    logic               r_err;
    logic [IW-1:0]      r_inst;
    logic               r_valid;
    logic               r_halt;

    logic               w_fetch_acc;
    logic               w_load_acc;
    logic               w_start_acc;
    logic               w_wr_ok;
    logic [AW:0]        w_wcnt_inc;
    logic               w_in_range;
    logic [BW+AW-1:0]   w_rd_addr;
    logic [BW+AW-1:0]   w_wr_addr;

    assign w_fetch_acc = i_fetch_req & o_fetch_ready;
    assign w_load_acc  = i_load_valid & o_load_ready;
    assign w_start_acc = i_load_start & (r_state == StIdle);
    // Bit AW of the write counter set means the bank is already full.
    assign w_wr_ok     = ~r_wcnt[AW];
    assign w_wcnt_inc  = w_wr_ok ? r_wcnt + (AW+1)'(1) : r_wcnt;
    assign w_in_range  = {1'b0, i_iptr} < r_len[i_bank_sel];
    assign w_rd_addr   = {i_bank_sel, i_iptr};
    assign w_wr_addr   = {r_tbank, r_wcnt[AW-1:0]};

    assign o_inst       = r_inst;
    assign o_inst_valid = r_valid;
    assign o_inst_halt  = r_halt;
    assign o_load_err   = r_err;

    // State register for the IDLE/LOAD loader FSM.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs; fetches are only served while idle.
    always_comb begin
        w_state_nxt   = r_state;
        o_fetch_ready = 1'b0;
        o_load_ready  = 1'b0;
        o_load_busy   = 1'b0;
        unique case (r_state)
            StIdle: begin
                o_fetch_ready = 1'b1;
                if (i_load_start) begin
                    w_state_nxt = StLoad;
                end
            end
            StLoad: begin
                o_load_ready = 1'b1;
                o_load_busy  = 1'b1;
                if (i_load_valid && i_load_last) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // Instruction storage: contents are intentionally not reset.
    always_ff @(posedge i_clk) begin
        if (w_load_acc && w_wr_ok) begin
            r_mem[w_wr_addr] <= i_load_data;
        end
    end

    // Loader bookkeeping: write counter, target bank and sticky overflow flag.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wcnt  <= '0;
            r_tbank <= '0;
            r_err   <= 1'b0;
        end else if (w_start_acc) begin
            r_wcnt  <= '0;
            r_tbank <= i_load_bank;
            r_err   <= 1'b0;
        end else if (w_load_acc) begin
            r_wcnt <= w_wcnt_inc;
            if (!w_wr_ok) begin
                r_err <= 1'b1;
            end
        end
    end

    // Per-bank loaded length; zeroed at load start so a partial load reads as halt.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int b = 0; b < NBANK; b++) begin
                r_len[b] <= '0;
            end
        end else if (w_start_acc) begin
            r_len[i_load_bank] <= '0;
        end else if (w_load_acc && i_load_last) begin
            r_len[r_tbank] <= w_wcnt_inc;
        end
    end

    // Registered fetch: instruction or halt word plus a one-cycle valid pulse.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_inst  <= '0;
            r_valid <= 1'b0;
            r_halt  <= 1'b0;
        end else begin
            r_valid <= w_fetch_acc;
            if (w_fetch_acc) begin
                r_inst <= w_in_range ? r_mem[w_rd_addr] : HALT_INST;
                r_halt <= ~w_in_range;
            end
        end
    end

endmodule

// File: tb/tb_instr_store.sv
// Directed self-checking bench for instr_store (default parameters).
module tb_instr_store;

    localparam int unsigned IW = 20;
    localparam int unsigned AW = 9;
    localparam int unsigned NBANK = 4;
    localparam logic [IW-1:0] HALT = 20'h70000;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [1:0]      bank_sel = '0;
    logic [AW-1:0]   iptr = '0;
    logic            fetch_req = 1'b0;
    logic            fetch_ready;
    logic [IW-1:0]   inst;
    logic            inst_valid;
    logic            inst_halt;
    logic            load_start = 1'b0;
    logic [1:0]      load_bank = '0;
    logic [IW-1:0]   load_data = '0;
    logic            load_valid = 1'b0;
    logic            load_last = 1'b0;
    logic            load_ready;
    logic            load_busy;
    logic            load_err;

    int n_tests = 0;
    int n_fail  = 0;

    instr_store #(
        .IW        (IW),
        .AW        (AW),
        .NBANK     (NBANK),
        .HALT_INST (HALT)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_bank_sel    (bank_sel),
        .i_iptr        (iptr),
        .i_fetch_req   (fetch_req),
        .o_fetch_ready (fetch_ready),
        .o_inst        (inst),
        .o_inst_valid  (inst_valid),
        .o_inst_halt   (inst_halt),
        .i_load_start  (load_start),
        .i_load_bank   (load_bank),
        .i_load_data   (load_data),
        .i_load_valid  (load_valid),
        .i_load_last   (load_last),
        .o_load_ready  (load_ready),
        .o_load_busy   (load_busy),
        .o_load_err    (load_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_fetch(input string tag, input logic [IW-1:0] exp_inst,
                             input logic exp_halt);
        chk({tag, "_valid"}, 32'(inst_valid), 32'd1);
        chk({tag, "_inst"}, 32'(inst), 32'(exp_inst));
        chk({tag, "_halt"}, 32'(inst_halt), 32'(exp_halt));
    endtask

    initial begin
        // Reset
        tick();
        tick();
        rst = 1'b0;
        chk("rst_inst", 32'(inst), 32'h0);
        chk("rst_valid", 32'(inst_valid), 32'h0);
        chk("rst_halt", 32'(inst_halt), 32'h0);
        chk("rst_fetch_ready", 32'(fetch_ready), 32'h1);
        chk("rst_load_ready", 32'(load_ready), 32'h0);
        chk("rst_load_busy", 32'(load_busy), 32'h0);
        chk("rst_load_err", 32'(load_err), 32'h0);

        // Fetch after reset halts
        bank_sel = 2'd0; iptr = '0; fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        chk_fetch("rst_fetch", HALT, 1'b1);
        tick();
        chk("valid_pulse", 32'(inst_valid), 32'h0);
        chk("inst_hold", 32'(inst), 32'(HALT));

        // Load bank 1 with three words
        load_start = 1'b1; load_bank = 2'd1;
        tick();
        load_start = 1'b0;
        chk("ld1_ready", 32'(load_ready), 32'h1);
        chk("ld1_busy", 32'(load_busy), 32'h1);
        chk("ld1_fetch_ready", 32'(fetch_ready), 32'h0);
        load_valid = 1'b1; load_data = 20'h16880;
        tick();
        load_data = 20'h19900;
        tick();
        load_data = 20'h19A03; load_last = 1'b1;
        tick();
        load_valid = 1'b0; load_last = 1'b0;
        chk("ld1_done_ready", 32'(load_ready), 32'h0);
        chk("ld1_done_fetch_ready", 32'(fetch_ready), 32'h1);

        // Back-to-back fetches from bank 1, then bank 0 still empty
        fetch_req = 1'b1; bank_sel = 2'd1; iptr = 9'd0;
        tick();
        chk_fetch("b1_i0", 20'h16880, 1'b0);
        iptr = 9'd1;
        tick();
        chk_fetch("b1_i1", 20'h19900, 1'b0);
        iptr = 9'd2;
        tick();
        chk_fetch("b1_i2", 20'h19A03, 1'b0);
        iptr = 9'd3;
        tick();
        chk_fetch("b1_i3", HALT, 1'b1);
        bank_sel = 2'd0; iptr = 9'd0;
        tick();
        chk_fetch("b0_still_empty", HALT, 1'b1);
        fetch_req = 1'b0;
        tick();
        chk("b2b_idle_valid", 32'(inst_valid), 32'h0);

        // Load bank 3 with valid gaps while a fetch is held pending
        load_start = 1'b1; load_bank = 2'd3;
        tick();
        load_start = 1'b0;
        fetch_req = 1'b1; bank_sel = 2'd3; iptr = 9'd1;
        load_valid = 1'b1; load_data = 20'hA1111;
        tick();
        chk("gap_fetch_ready", 32'(fetch_ready), 32'h0);
        chk("gap_valid0", 32'(inst_valid), 32'h0);
        load_valid = 1'b0; load_data = 20'hBBBBB;
        tick();
        chk("gap_valid1", 32'(inst_valid), 32'h0);
        load_valid = 1'b1; load_data = 20'hA2222;
        tick();
        load_valid = 1'b0; load_data = 20'hCCCCC;
        tick();
        chk("gap_valid2", 32'(inst_valid), 32'h0);
        load_valid = 1'b1; load_data = 20'hA3333; load_last = 1'b1;
        tick();
        load_valid = 1'b0; load_last = 1'b0;
        chk("gap_end_valid", 32'(inst_valid), 32'h0);
        chk("gap_end_fetch_ready", 32'(fetch_ready), 32'h1);
        tick();
        chk_fetch("gap_held_i1", 20'hA2222, 1'b0);
        iptr = 9'd2;
        tick();
        chk_fetch("gap_i2", 20'hA3333, 1'b0);
        iptr = 9'd3;
        tick();
        chk_fetch("gap_i3", HALT, 1'b1);
        fetch_req = 1'b0;

        // Overflow bank 2 with 2**AW+2 words
        load_start = 1'b1; load_bank = 2'd2;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < (1 << AW) + 2; i++) begin
            load_valid = 1'b1;
            load_data = 20'hC0000 | IW'(i);
            load_last = (i == (1 << AW) + 1);
            tick();
        end
        load_valid = 1'b0; load_last = 1'b0;
        chk("ovf_err", 32'(load_err), 32'h1);
        chk("ovf_fetch_ready", 32'(fetch_ready), 32'h1);
        fetch_req = 1'b1; bank_sel = 2'd2; iptr = 9'd511;
        tick();
        chk_fetch("ovf_i511", 20'hC01FF, 1'b0);
        iptr = 9'd0;
        tick();
        chk_fetch("ovf_i0", 20'hC0000, 1'b0);
        fetch_req = 1'b0;
        tick();
        chk("ovf_err_sticky", 32'(load_err), 32'h1);

        // Simultaneous fetch and load_start on bank 1 returns old contents
        fetch_req = 1'b1; bank_sel = 2'd1; iptr = 9'd0;
        load_start = 1'b1; load_bank = 2'd1;
        tick();
        fetch_req = 1'b0; load_start = 1'b0;
        chk_fetch("sim_old", 20'h16880, 1'b0);
        chk("sim_err_clr", 32'(load_err), 32'h0);
        chk("sim_busy", 32'(load_busy), 32'h1);
        load_valid = 1'b1; load_data = 20'h55555;
        tick();
        load_valid = 1'b0;

        // Reset mid-load
        rst = 1'b1;
        #2;
        chk("mrst_busy", 32'(load_busy), 32'h0);
        chk("mrst_fetch_ready", 32'(fetch_ready), 32'h1);
        chk("mrst_load_ready", 32'(load_ready), 32'h0);
        chk("mrst_valid", 32'(inst_valid), 32'h0);
        chk("mrst_inst", 32'(inst), 32'h0);
        rst = 1'b0;
        fetch_req = 1'b1; bank_sel = 2'd1; iptr = 9'd0;
        tick();
        chk_fetch("mrst_b1", HALT, 1'b1);
        bank_sel = 2'd3; iptr = 9'd1;
        tick();
        chk_fetch("mrst_b3", HALT, 1'b1);
        bank_sel = 2'd2; iptr = 9'd5;
        tick();
        chk_fetch("mrst_b2", HALT, 1'b1);
        fetch_req = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
